dram_feature_wr_addr: RTL
=========================

# dram_feature_wr_addr

Write-side address generator for output feature maps in the CNN accelerator. It pairs with the DRAM feature read-address path: it turns per-row completion pulses from the on-chip output buffer into DRAM byte addresses and burst lengths. It hands them to the AXI write engine over a valid/ready handshake and reports layer completion. It sits between the output-buffer row sequencer and the AXI write master.

## Interface
Parameters:
- W_WIDTH, 10, height/width/row-index width
- LITEWIDTH, 32, AXI-Lite register and DRAM address width
- DEPTHWIDTH, 9, channel-group count width
- AXIWIDTH, 128, AXI data width in bits; one beat = AXIWIDTH/8 bytes
- PENDWIDTH, 3, width of the pending-row counter

Ports:
- I_clk  in  1  clock; all logic on the rising edge
- I_rst  in  1  synchronous, active-high reset
- I_ap_start  in  1  layer start level; only the rising edge is acted on
- I_coMemGroup  in  DEPTHWIDTH  output channel groups per pixel (beats per pixel)
- I_feature_out_base_addr  in  LITEWIDTH  byte base address of the output map
- I_oheight  in  W_WIDTH  output rows
- I_owidth  in  W_WIDTH  output pixels per row
- I_row_done  in  1  one-cycle pulse: one output row is ready in the buffer
- I_wr_ready  in  1  write engine accepts the request
- O_wr_valid  out  1  request valid
- O_dram_feature_wr_addr  out  LITEWIDTH  byte address of the row
- O_dram_feature_wr_len  out  W_WIDTH+DEPTHWIDTH  row length in beats
- O_busy  out  1  layer in progress
- O_layer_done  out  1  one-cycle pulse after the last row is accepted
- O_ovf  out  1  sticky: I_row_done was dropped because the pending counter was full

## Operation
- The start edge is detected against a registered copy of I_ap_start. It is honoured only in IDLE and ignored otherwise.
- FSM states:
  - IDLE
    - start edge: latch base, oheight, owidth, coMemGroup; clear ovf, pending, row counter → SETUP
  - SETUP
    - len = coMemGroup*owidth (unsigned, full width); stride = len << log2(AXIWIDTH/8); addr = base
    - → RUN, or → DONE if oheight == 0
  - RUN
    - issues one request per pending row
    - on the handshake of row oheight-1 → DONE
  - DONE
    - pulse O_layer_done → IDLE
- Pending counter:
  - I_row_done alone: +1
  - handshake alone: -1
  - both in the same cycle: unchanged
  - I_row_done while full (2^PENDWIDTH-1) and no handshake: dropped; O_ovf set
  - I_row_done outside RUN/SETUP: ignored
- Request rules:
  - O_wr_valid is registered. It is set when in RUN, pending != 0 and no request is outstanding.
  - Once set, O_wr_valid, addr and len are held stable until I_wr_ready.
  - On handshake: valid clears; addr += stride (wraps modulo 2^LITEWIDTH); row counter +1.
- Address arithmetic: stride is zero-extended to LITEWIDTH before the add. len is constant for the whole layer.

## Timing
- Reset values: O_wr_valid 0, addr 0, len 0, O_busy 0, O_layer_done 0, O_ovf 0; FSM in IDLE; pending 0.
- I_rst mid-layer aborts the layer immediately. No O_layer_done is produced.
- Start sequence:
  - I_ap_start rises at edge t
  - edge detected at t+1 (SETUP, O_busy=1)
  - RUN at t+2
- I_row_done sampled at edge n → pending at n → O_wr_valid high after edge n+1.
- Handshake at edge k → O_wr_valid low after k. It may re-assert after k+1 if pending remains. Peak rate is one request per 2 cycles.
- Last handshake at edge k → DONE after k → O_layer_done high for the cycle after k+1; O_busy low at the same point.

## Configuration
- DRAM_FEATURE_WR_STATS_EN
  - defined: adds output O_stall_cycles (32 bits). It counts cycles with O_wr_valid && !I_wr_ready, saturates at all-ones, clears on the accepted start edge, and holds after the layer.
  - undefined: the port and the counter do not exist; all other behaviour is identical.

## Structure
- Shared package cnn_dram_pkg:
  - FSM state enum (IDLE, SETUP, RUN, DONE)
  - beat-bytes constant and its log2, derived from AXIWIDTH
  - length-width localparam
- Single module, no sub-modules. The len multiply is one registered multiplier; it may map to a DSP but is not instantiated as a separate unit.

## Test plan
- Basic layer
  - stimulus: base 0x1000_0000, coMemGroup 2, owidth 8, oheight 3, AXIWIDTH 128; three row_done pulses; ready tied 1
  - response: len 16; addrs 0x1000_0000, 0x1000_0100, 0x1000_0200; one O_layer_done pulse
- Backpressure
  - stimulus: ready low for 5 cycles with valid high
  - response: addr/len stable throughout; pending stays correct; O_stall_cycles = 5 under DRAM_FEATURE_WR_STATS_EN
- Burst of row_done
  - stimulus: 7 back-to-back pulses with ready low, then an 8th pulse
  - response: pending 7; 8th dropped; O_ovf = 1; 7 requests issued afterwards
- Simultaneous events
  - stimulus: row_done coincides with a handshake
  - response: pending unchanged; next request follows
- Edge cases
  - stimulus: oheight 0
  - response: O_layer_done at t+3 with no request
  - stimulus: start edge during RUN
  - response: ignored
  - stimulus: base 0xFFFF_FF00 with stride 0x100
  - response: second address wraps to 0x0000_0000
- Reset mid-layer
  - stimulus: I_rst after row 1
  - response: all outputs at reset values next cycle; a new start then produces addresses from the new base

Source files
------------

// File: rtl/cnn_dram_pkg.sv
// cnn_dram_pkg: shared FSM states and beat/length geometry for the DRAM feature address paths
package cnn_dram_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} wr_state_e;
  localparam int BEAT_BYTES_DEF = 16;
  localparam int AXIWIDTH_DEF = BEAT_BYTES_DEF * 8;
  function automatic int beat_log2(input int axiwidth);
    return $clog2(axiwidth / 8);
  endfunction
  function automatic int len_width(input int w_width, input int depthwidth);
    return w_width + depthwidth;
  endfunction
endpackage

// File: rtl/dram_feature_wr_addr.sv
// dram_feature_wr_addr: turns output-row completions into DRAM write requests (addr/len, valid/ready)
// DRAM_FEATURE_WR_STATS_EN adds O_stall_cycles, a saturating count of backpressured cycles
module dram_feature_wr_addr
  import cnn_dram_pkg::*;
#(
  parameter int W_WIDTH    = 10,
  parameter int LITEWIDTH  = 32,
  parameter int DEPTHWIDTH = 9,
  parameter int AXIWIDTH   = AXIWIDTH_DEF,
  parameter int PENDWIDTH  = 3
) (
  input  logic                          I_clk,
  input  logic                          I_rst,
  input  logic                          I_ap_start,
  input  logic [DEPTHWIDTH-1:0]         I_coMemGroup,
  input  logic [LITEWIDTH-1:0]          I_feature_out_base_addr,
  input  logic [W_WIDTH-1:0]            I_oheight,
  input  logic [W_WIDTH-1:0]            I_owidth,
  input  logic                          I_row_done,
  input  logic                          I_wr_ready,
  output logic                          O_wr_valid,
  output logic [LITEWIDTH-1:0]          O_dram_feature_wr_addr,
  output logic [W_WIDTH+DEPTHWIDTH-1:0] O_dram_feature_wr_len,
  output logic                          O_busy,
  output logic                          O_layer_done,
  output logic                          O_ovf
`ifdef DRAM_FEATURE_WR_STATS_EN
  , output logic [31:0]                 O_stall_cycles
`endif
);
  localparam int LEN_W = len_width(W_WIDTH, DEPTHWIDTH);
  localparam int SHIFT = beat_log2(AXIWIDTH);
  wr_state_e state, state_d;
  logic start_q, start_ok, hs, rd, last_row;
  logic [LITEWIDTH-1:0] base_q, stride_q;
  logic [W_WIDTH-1:0] oh_q, ow_q, row_q;
  logic [DEPTHWIDTH-1:0] cmg_q;
  logic [PENDWIDTH-1:0] pend_q;
  logic [LEN_W-1:0] prod;
  logic [LEN_W+SHIFT-1:0] stride_w;
  assign start_ok = state == IDLE && I_ap_start && !start_q;
  assign hs = O_wr_valid && I_wr_ready;
  assign rd = I_row_done && (state == SETUP || state == RUN);
  assign last_row = row_q == oh_q - W_WIDTH'(1);
  assign prod = LEN_W'(cmg_q) * LEN_W'(ow_q);
  assign stride_w = (LEN_W+SHIFT)'(prod) << SHIFT;
  assign O_busy = state != IDLE;
  always_comb begin
    state_d = state;
    state_d = start_ok ? SETUP
            : state == SETUP ? (oh_q == '0 ? DONE : RUN)
            : (state == RUN && hs && last_row) ? DONE
            : state == DONE ? IDLE
            : state;
  end
  always_ff @(posedge I_clk) begin
    if (I_rst) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      start_q <= 1'b0;
      O_layer_done <= 1'b0;
      O_wr_valid <= 1'b0;
      O_dram_feature_wr_addr <= '0;
      O_dram_feature_wr_len <= '0;
      O_ovf <= 1'b0;
      base_q <= '0;
      stride_q <= '0;
      oh_q <= '0;
      ow_q <= '0;
      cmg_q <= '0;
      row_q <= '0;
      pend_q <= '0;
    end else begin
      start_q <= I_ap_start;
      O_layer_done <= state == DONE;
      if (start_ok) begin
        base_q <= I_feature_out_base_addr;
        oh_q <= I_oheight;
        ow_q <= I_owidth;
        cmg_q <= I_coMemGroup;
        row_q <= '0;
        O_ovf <= 1'b0;
      end
      if (state == SETUP) begin
        O_dram_feature_wr_len <= prod;
        stride_q <= LITEWIDTH'(stride_w);
        O_dram_feature_wr_addr <= base_q;
      end
      if (hs) begin
        O_wr_valid <= 1'b0;
        O_dram_feature_wr_addr <= O_dram_feature_wr_addr + stride_q;
        row_q <= row_q + W_WIDTH'(1);
      end else if (state == RUN && pend_q != '0 && !O_wr_valid) O_wr_valid <= 1'b1;
      // a handshake coinciding with a new row leaves the count unchanged
      if (start_ok) pend_q <= '0;
      else if (rd && !hs && &pend_q) O_ovf <= 1'b1;
      else if (rd && !hs) pend_q <= pend_q + PENDWIDTH'(1);
      else if (hs && !rd) pend_q <= pend_q - PENDWIDTH'(1);
    end
  end
`ifdef DRAM_FEATURE_WR_STATS_EN
  always_ff @(posedge I_clk) begin
    if (I_rst) O_stall_cycles <= '0;
    else if (start_ok) O_stall_cycles <= '0;
    else if (O_wr_valid && !I_wr_ready && !(&O_stall_cycles)) O_stall_cycles <= O_stall_cycles + 32'd1;
  end
`endif
endmodule
